cmp_serial_pipe: RTL and testbench

//   Multi-cycle, parametrised magnitude comparator for the ALU/branch-unit datapath.

---
 rtl/cmp_serial_pipe.sv | 185 ++++++++++++++++++
 tb/tb_cmp_serial_pipe.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_serial_pipe.sv
// cmp_serial_pipe: multi-cycle magnitude comparator for the ALU/branch-unit datapath.
// Walks the latched operands one CHUNK-bit slice per cycle, MSB slice first, and
// reports unsigned-less, signed-less and equal together behind a valid/ready pair.
// The signed result is derived from the unsigned slice decision plus the two sign
// bits, so no subtractor is needed anywhere.
module cmp_serial_pipe #(
    parameter  int WIDTH      = 32,
    parameter  int CHUNK      = 8,
    parameter  int EARLY_EXIT = 1,
    localparam int NCHUNK     = WIDTH / CHUNK,
    localparam int CW         = $clog2(NCHUNK + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ul,
    output logic             sl,
    output logic             eq,
    output logic [CW-1:0]    chunks_used
);

    // Reject illegal geometries at elaboration time.
    if (WIDTH < 2) begin : g_bad_width
        $error("cmp_serial_pipe: WIDTH must be >= 2");
    end
    if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_chunk
        $error("cmp_serial_pipe: WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_accept;
    logic              w_finish;

    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [CW-1:0]     r_idx;
    logic              r_decided;
    logic              r_ul_u;

    logic              r_out_valid;
    logic              r_ul;
    logic              r_sl;
    logic              r_eq;
    logic [CW-1:0]     r_cu;

    logic [CHUNK-1:0]  w_a_slice;
    logic [CHUNK-1:0]  w_b_slice;
    logic              w_slice_diff;
    logic              w_decided_now;
    logic              w_ul_now;
    logic              w_last_slice;
    logic              w_done_cond;
    logic              w_sign_diff;

    // Select the slice addressed by r_idx (slice 0 is the most significant one).
    always_comb begin
        w_a_slice = {CHUNK{1'b0}};
        w_b_slice = {CHUNK{1'b0}};
        for (int k = 0; k < NCHUNK; k++) begin
            w_a_slice = w_a_slice | (r_a[WIDTH-1-k*CHUNK -: CHUNK] & {CHUNK{r_idx == CW'(k)}});
            w_b_slice = w_b_slice | (r_b[WIDTH-1-k*CHUNK -: CHUNK] & {CHUNK{r_idx == CW'(k)}});
        end
    end

    assign w_slice_diff  = (w_a_slice != w_b_slice);
    assign w_decided_now = r_decided | w_slice_diff;
    // Only the first differing slice decides; later slices cannot change the outcome.
    assign w_ul_now      = r_decided ? r_ul_u : (w_slice_diff & (w_a_slice < w_b_slice));
    assign w_last_slice  = (r_idx == CW'(NCHUNK - 1));
    assign w_done_cond   = ((EARLY_EXIT != 0) && w_slice_diff) || w_last_slice;
    // Differing sign bits invert the unsigned verdict to give the signed one.
    assign w_sign_diff   = r_a[WIDTH-1] ^ r_b[WIDTH-1];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and transaction strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_BUSY;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_BUSY: begin
                if (w_done_cond) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_BUSY;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand latch, slice walker and running first-difference decision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a       <= {WIDTH{1'b0}};
            r_b       <= {WIDTH{1'b0}};
            r_idx     <= {CW{1'b0}};
            r_decided <= 1'b0;
            r_ul_u    <= 1'b0;
        end else if (w_accept) begin
            r_a       <= a;
            r_b       <= b;
            r_idx     <= {CW{1'b0}};
            r_decided <= 1'b0;
            r_ul_u    <= 1'b0;
        end else if (r_state == S_BUSY) begin
            r_decided <= w_decided_now;
            r_ul_u    <= w_ul_now;
            if (!w_finish) begin
                r_idx <= r_idx + CW'(1);
            end else begin
                r_idx <= r_idx;
            end
        end else begin
            r_idx <= r_idx;
        end
    end

    // Result registers: loaded on the finishing slice, held until the next finish.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_ul        <= 1'b0;
            r_sl        <= 1'b0;
            r_eq        <= 1'b0;
            r_cu        <= {CW{1'b0}};
        end else if (w_finish) begin
            r_out_valid <= 1'b1;
            r_ul        <= w_ul_now;
            r_eq        <= ~w_decided_now;
            r_sl        <= w_decided_now & (w_ul_now ^ w_sign_diff);
            r_cu        <= r_idx + CW'(1);
        end else if ((r_state == S_DONE) && out_ready) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = r_out_valid;
    assign ul          = r_ul;
    assign sl          = r_sl;
    assign eq          = r_eq;
    assign chunks_used = r_cu;

endmodule

// File: tb/tb_cmp_serial_pipe.sv
// Self-checking bench for cmp_serial_pipe. Eight configurations are instantiated
// side by side; one is selected at a time and driven through shared stimulus.
// Expected results come from plain integer comparisons on the full operands.
module tb_cmp_serial_pipe;

    localparam int NCFG = 8;

    function automatic int cfg_w(int i);
        case (i)
            0, 1:    return 32;
            2, 3:    return 16;
            4, 5:    return 32;
            6, 7:    return 64;
            default: return 32;
        endcase
    endfunction

    function automatic int cfg_c(int i);
        case (i)
            0, 1:    return 8;
            2, 3:    return 4;
            4, 5:    return 32;
            6, 7:    return 8;
            default: return 8;
        endcase
    endfunction

    function automatic int cfg_e(int i);
        return ((i % 2) == 0) ? 1 : 0;
    endfunction

    logic        clk;
    logic        rst;
    logic        iv;
    logic        ordy;
    logic [63:0] a;
    logic [63:0] b;
    int          sel;

    wire [NCFG-1:0] ir_all;
    wire [NCFG-1:0] ov_all;
    wire [NCFG-1:0] ul_all;
    wire [NCFG-1:0] sl_all;
    wire [NCFG-1:0] eq_all;
    wire [7:0]      cu_all [NCFG];

    int nchk;
    int nerr;

    genvar g;
    for (g = 0; g < NCFG; g++) begin : g_dut
        localparam int W   = cfg_w(g);
        localparam int C   = cfg_c(g);
        localparam int E   = cfg_e(g);
        localparam int NC  = W / C;
        localparam int CWL = $clog2(NC + 1);
        logic [CWL-1:0] cu;
        logic ir, ov, ul, sl, eq;
        cmp_serial_pipe #(.WIDTH(W), .CHUNK(C), .EARLY_EXIT(E)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .in_valid    (iv && (sel == g)),
            .in_ready    (ir),
            .a           (a[W-1:0]),
            .b           (b[W-1:0]),
            .out_valid   (ov),
            .out_ready   (ordy && (sel == g)),
            .ul          (ul),
            .sl          (sl),
            .eq          (eq),
            .chunks_used (cu)
        );
        assign ir_all[g] = ir;
        assign ov_all[g] = ov;
        assign ul_all[g] = ul;
        assign sl_all[g] = sl;
        assign eq_all[g] = eq;
        assign cu_all[g] = 8'(cu);
    end

    logic       s_ir, s_ov, s_ul, s_sl, s_eq;
    logic [7:0] s_cu;
    logic [2:0] sel3;
    assign sel3 = sel[2:0];
    assign s_ir = ir_all[sel3];
    assign s_ov = ov_all[sel3];
    assign s_ul = ul_all[sel3];
    assign s_sl = sl_all[sel3];
    assign s_eq = eq_all[sel3];
    assign s_cu = cu_all[sel3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s (cfg %0d): got %h expected %h", name, sel, act, exp);
        end
    endtask

    function automatic logic [63:0] wmask(int w);
        logic [63:0] one;
        one = 64'd1;
        return (w == 64) ? {64{1'b1}} : ((one << w) - 64'd1);
    endfunction

    // Reference: whole-operand compares; slice count from the highest differing bit.
    task automatic model(input int cfg, input logic [63:0] x, input logic [63:0] y,
                         output logic eul, output logic esl, output logic eeq, output int ecu);
        int w;
        int c;
        int p;
        logic [63:0] xa, ya, d;
        w   = cfg_w(cfg);
        c   = cfg_c(cfg);
        xa  = x & wmask(w);
        ya  = y & wmask(w);
        eul = (xa < ya);
        esl = ($signed(xa << (64 - w)) < $signed(ya << (64 - w)));
        eeq = (xa == ya);
        if (eeq || (cfg_e(cfg) == 0)) begin
            ecu = w / c;
        end else begin
            d = xa ^ ya;
            p = 0;
            for (int i = 0; i < 64; i++) begin
                if (d[i]) p = i;
            end
            ecu = (w - 1 - p) / c + 1;
        end
    endtask

    function automatic logic [63:0] pick(int w);
        logic [63:0] v;
        logic [63:0] one;
        one = 64'd1;
        case ($urandom_range(0, 7))
            0:       v = 64'd0;
            1:       v = wmask(w);
            2:       v = one << (w - 1);
            3:       v = wmask(w) >> 1;
            default: v = {$urandom, $urandom} & wmask(w);
        endcase
        return v;
    endfunction

    // One transaction on the selected DUT; entered and left at a falling edge.
    task automatic run_txn(input int cfg, input logic [63:0] x, input logic [63:0] y,
                           input logic eul, input logic esl, input logic eeq, input int ecu,
                           input bit stall);
        int n;
        int hold;
        sel = cfg;
        if (stall) repeat ($urandom_range(0, 2)) @(negedge clk);
        a  = x;
        b  = y;
        iv = 1'b1;
        chk("in_ready_idle", 64'(s_ir), 64'd1);
        @(negedge clk);
        chk("in_ready_busy", 64'(s_ir), 64'd0);
        // operands and in_valid must be ignored once accepted
        iv = stall ? 1'($urandom_range(0, 1)) : 1'b0;
        a  = {$urandom, $urandom};
        b  = {$urandom, $urandom};
        n  = 0;
        while (!s_ov && (n < 80)) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 64'(n), 64'(ecu));
        chk("result", {56'd0, s_ov, s_ul, s_sl, s_eq, 4'd0}, {56'd0, 1'b1, eul, esl, eeq, 4'd0});
        chk("chunks_used", 64'(s_cu), 64'(ecu));
        hold = stall ? $urandom_range(0, 3) : 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold", {52'd0, s_ir, s_ov, s_ul, s_sl, s_eq, 7'd0} | 64'(s_cu),
                {52'd0, 1'b0, 1'b1, eul, esl, eeq, 7'd0} | 64'(ecu));
        end
        iv   = 1'b0;
        ordy = 1'b1;
        @(negedge clk);
        ordy = 1'b0;
        chk("retire", {62'd0, s_ov, s_ir}, {62'd0, 1'b0, 1'b1});
    endtask

    typedef struct {
        int          cfg;
        logic [63:0] a;
        logic [63:0] b;
        logic        ul;
        logic        sl;
        logic        eq;
        int          cu;
    } vec_t;

    vec_t vt [12];

    initial begin
        logic        eul, esl, eeq;
        int          ecu;
        int          n;
        logic [63:0] x, y;
        logic [63:0] one;

        one = 64'd1;
        vt[0]  = '{0, 64'h5,                 64'h7,                 1'b1, 1'b1, 1'b0, 4};
        vt[1]  = '{0, 64'h8000_0000,         64'h1,                 1'b0, 1'b1, 1'b0, 1};
        vt[2]  = '{1, 64'h8000_0000,         64'h1,                 1'b0, 1'b1, 1'b0, 4};
        vt[3]  = '{0, 64'hDEAD_BEEF,         64'hDEAD_BEEF,         1'b0, 1'b0, 1'b1, 4};
        vt[4]  = '{0, 64'hFFFF_FFFF,         64'h0,                 1'b0, 1'b1, 1'b0, 1};
        vt[5]  = '{0, 64'h3,                 64'hFFFF_FFFF,         1'b1, 1'b0, 1'b0, 1};
        vt[6]  = '{5, 64'h5,                 64'h7,                 1'b1, 1'b1, 1'b0, 1};
        vt[7]  = '{6, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0, 1};
        vt[8]  = '{3, 64'h7FFF,              64'h8000,              1'b1, 1'b0, 1'b0, 4};
        vt[9]  = '{2, 64'h1234,              64'h1235,              1'b1, 1'b1, 1'b0, 4};
        vt[10] = '{7, 64'h1,                 64'h0,                 1'b0, 1'b0, 1'b0, 8};
        vt[11] = '{4, 64'hA5A5_A5A5,         64'hA5A5_A5A5,         1'b0, 1'b0, 1'b1, 1};

        nchk = 0;
        nerr = 0;
        sel  = 0;
        rst  = 1'b0;
        iv   = 1'b0;
        ordy = 1'b0;
        a    = 64'd0;
        b    = 64'd0;

        // Reset state
        #1 rst = 1'b1;
        #1;
        chk("reset_outputs", {59'd0, s_ov, s_ul, s_sl, s_eq, 1'b0} | 64'(s_cu), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_reset", 64'(s_ir), 64'd1);

        // Directed vectors
        for (int i = 0; i < 12; i++) begin
            run_txn(vt[i].cfg, vt[i].a, vt[i].b, vt[i].ul, vt[i].sl, vt[i].eq, vt[i].cu, 1'b0);
        end

        // Back-pressure in DONE with in_valid held high throughout
        sel = 0;
        a = 64'h5; b = 64'h7; iv = 1'b1;
        @(negedge clk);
        a = 64'h9; b = 64'h2;
        n = 0;
        while (!s_ov && (n < 40)) begin
            @(negedge clk);
            n++;
        end
        chk("bp_latency", 64'(n), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk("bp_hold", {56'd0, s_ir, s_ov, s_ul, s_sl, s_eq, 3'd0},
                {56'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0});
            chk("bp_cu", 64'(s_cu), 64'd4);
            if (i < 3) @(negedge clk);
        end
        ordy = 1'b1;
        @(negedge clk);
        ordy = 1'b0;
        chk("bp_back_to_idle", {62'd0, s_ov, s_ir}, {62'd0, 1'b0, 1'b1});
        @(negedge clk);
        chk("bp_new_accept", 64'(s_ir), 64'd0);
        iv = 1'b0;
        n = 0;
        while (!s_ov && (n < 40)) begin
            @(negedge clk);
            n++;
        end
        chk("bp_second", {59'd0, s_ov, s_ul, s_sl, s_eq, 1'b0} | 64'(s_cu),
            {59'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0} | 64'd4);
        ordy = 1'b1;
        @(negedge clk);
        ordy = 1'b0;

        // Asynchronous reset in the middle of BUSY, between clock edges
        a = 64'h5; b = 64'h7; iv = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        iv  = 1'b0;
        rst = 1'b1;
        #1;
        chk("midbusy_reset", {58'd0, s_ir, s_ov, s_ul, s_sl, s_eq, 1'b0} | 64'(s_cu),
            {58'd0, 1'b1, 5'd0});
        #1 rst = 1'b0;
        chk("ready_after_pulse", 64'(s_ir), 64'd1);
        @(negedge clk);
        run_txn(0, 64'h3, 64'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1, 1'b0);

        // Randomised pairs on every configuration with stalls
        for (int c = 0; c < NCFG; c++) begin
            for (int i = 0; i < 260; i++) begin
                x = pick(cfg_w(c));
                if ($urandom_range(0, 9) < 3) begin
                    y = x ^ (one << $urandom_range(0, cfg_w(c) - 1));
                end else if ($urandom_range(0, 9) == 0) begin
                    y = x;
                end else begin
                    y = pick(cfg_w(c));
                end
                model(c, x, y, eul, esl, eeq, ecu);
                run_txn(c, x, y, eul, esl, eeq, ecu, 1'b1);
            end
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
